// File: rtl/multicycle_controller_if.sv
// Control-side bundle between the multicycle controller and the accumulator datapath / memory port.
// master = controller (drives strobes), slave = datapath and memory (drive opcode, flags, ready).
interface multicycle_controller_if #(
   parameter int OP_W = 3
);
   logic [OP_W-1:0] op_code;
   logic            ac_zero;
   logic            mem_ready;
   logic            rd_mem;
   logic            wr_mem;
   logic            ir_on_adr;
   logic            pc_on_adr;
   logic            ld_ir;
   logic            ld_ac;
   logic            ld_pc;
   logic            inc_pc;
   logic            clr_pc;
   logic            pass_add;
   logic            halted;
   logic            illegal_op;

   // Memory handshake: rd_mem/wr_mem act as "valid" and stay high until a cycle
   // with mem_ready=1; that cycle completes the access. mem_ready is ignored
   // whenever neither strobe is asserted.
   modport master (
      input  op_code, ac_zero, mem_ready,
      output rd_mem, wr_mem, ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc,
             inc_pc, clr_pc, pass_add, halted, illegal_op
   );

   modport slave (
      output op_code, ac_zero, mem_ready,
      input  rd_mem, wr_mem, ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc,
             inc_pc, clr_pc, pass_add, halted, illegal_op
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle FETCH / WAIT / EXECUTE / HALT control FSM for the accumulator CPU.
// Optional feature: define ILLEGAL_OP_TRAP_EN to trap opcode 111 into HALT with a sticky illegal_op.
module multicycle_controller #(
   parameter int OP_W        = 3,
   parameter int WAIT_CYCLES = 1,
   parameter int CNT_W       = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   multicycle_controller_if.master  bus,
   output logic [2:0]               state_dbg
);

   localparam logic [2:0] S_RESET = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_EXEC  = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_STOR = 3'b010;
   localparam logic [2:0] OP_JMP  = 3'b011;
   localparam logic [2:0] OP_JZ   = 3'b100;
   localparam logic [2:0] OP_NOP  = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b110;

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

   logic [2:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic [OP_W-1:0]  op_full;
   logic [2:0]       op;
   logic             illegal_q;

   logic rd_mem, wr_mem, ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc;
   logic inc_pc, clr_pc, pass_add, halted;

   assign op_full = bus.op_code;
   assign op      = op_full[2:0];
   assign cnt_inc = cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_RESET;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef ILLEGAL_OP_TRAP_EN
   logic trap;

   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_q <= 1'b0;
      end else if (trap) begin
         illegal_q <= 1'b1;
      end
   end
`else
   assign illegal_q = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rd_mem    = 1'b0;
      wr_mem    = 1'b0;
      ir_on_adr = 1'b0;
      pc_on_adr = 1'b0;
      ld_ir     = 1'b0;
      ld_ac     = 1'b0;
      ld_pc     = 1'b0;
      inc_pc    = 1'b0;
      clr_pc    = 1'b0;
      pass_add  = 1'b0;
      halted    = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      trap      = 1'b0;
`endif
      case (state)
         S_RESET: begin
            clr_pc    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            pc_on_adr = 1'b1;
            rd_mem    = 1'b1;
            if (bus.mem_ready) begin
               ld_ir     = 1'b1;
               inc_pc    = 1'b1;
               state_nxt = (WAIT_CYCLES == 0) ? S_EXEC : S_WAIT;
               cnt_nxt   = '0;
            end
         end
         // Counter value after increment equals the number of WAIT cycles spent so far.
         S_WAIT: begin
            if (cnt_inc == WAIT_LAST) begin
               state_nxt = S_EXEC;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt_inc;
            end
         end
         S_EXEC: begin
            state_nxt = S_FETCH;
            case (op)
               OP_ADD: begin
                  pass_add = 1'b1;
                  ld_ac    = 1'b1;
               end
               OP_LOAD: begin
                  ir_on_adr = 1'b1;
                  rd_mem    = 1'b1;
                  ld_ac     = bus.mem_ready;
                  if (!bus.mem_ready) state_nxt = S_EXEC;
               end
               OP_STOR: begin
                  ir_on_adr = 1'b1;
                  wr_mem    = 1'b1;
                  if (!bus.mem_ready) state_nxt = S_EXEC;
               end
               OP_JMP:  ld_pc = 1'b1;
               OP_JZ:   ld_pc = bus.ac_zero;
               OP_NOP:  state_nxt = S_FETCH;
               OP_HALT: state_nxt = S_HALT;
               default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                  trap      = 1'b1;
                  state_nxt = S_HALT;
`else
                  state_nxt = S_FETCH;
`endif
               end
            endcase
         end
         S_HALT: halted = 1'b1;
         default: state_nxt = S_RESET;
      endcase
   end

   assign bus.rd_mem     = rd_mem;
   assign bus.wr_mem     = wr_mem;
   assign bus.ir_on_adr  = ir_on_adr;
   assign bus.pc_on_adr  = pc_on_adr;
   assign bus.ld_ir      = ld_ir;
   assign bus.ld_ac      = ld_ac;
   assign bus.ld_pc      = ld_pc;
   assign bus.inc_pc     = inc_pc;
   assign bus.clr_pc     = clr_pc;
   assign bus.pass_add   = pass_add;
   assign bus.halted     = halted;
   assign bus.illegal_op = illegal_q;
   assign state_dbg      = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle vector bench for multicycle_controller: one instance with 3 wait states,
// one with none. Build with or without +define+ILLEGAL_OP_TRAP_EN.
module tb_multicycle_controller;

   localparam logic [2:0] ST_RESET = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_EXEC  = 3'd3;
   localparam logic [2:0] ST_HALT  = 3'd4;

   // Output word: {rd_mem, wr_mem, ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass_add, halted, illegal_op}
   localparam logic [11:0] O_RD   = 12'h800;
   localparam logic [11:0] O_WR   = 12'h400;
   localparam logic [11:0] O_IRA  = 12'h200;
   localparam logic [11:0] O_PCA  = 12'h100;
   localparam logic [11:0] O_LDIR = 12'h080;
   localparam logic [11:0] O_LDAC = 12'h040;
   localparam logic [11:0] O_LDPC = 12'h020;
   localparam logic [11:0] O_INC  = 12'h010;
   localparam logic [11:0] O_CLR  = 12'h008;
   localparam logic [11:0] O_PASS = 12'h004;
   localparam logic [11:0] O_HLT  = 12'h002;
   localparam logic [11:0] O_ILL  = 12'h001;

   typedef struct {
      logic        sel;
      logic        rst;
      logic [2:0]  op;
      logic        az;
      logic        mr;
      logic [2:0]  st;
      logic [11:0] out;
      string       name;
   } vec_t;

   logic        clk;
   logic        rst3, rst0;
   logic [2:0]  st3, st0;
   logic [11:0] out3, out0;
   vec_t        vecs[$];
   logic [14:0] exp_q[$];
   int          vectors_applied;
   int          miscompares;

   multicycle_controller_if #(.OP_W(3)) bus3 ();
   multicycle_controller_if #(.OP_W(3)) bus0 ();

   multicycle_controller #(.OP_W(3), .WAIT_CYCLES(3), .CNT_W(4)) dut3 (
      .clk(clk), .reset(rst3), .bus(bus3), .state_dbg(st3)
   );
   multicycle_controller #(.OP_W(3), .WAIT_CYCLES(0), .CNT_W(4)) dut0 (
      .clk(clk), .reset(rst0), .bus(bus0), .state_dbg(st0)
   );

   assign out3 = {bus3.rd_mem, bus3.wr_mem, bus3.ir_on_adr, bus3.pc_on_adr, bus3.ld_ir, bus3.ld_ac,
                  bus3.ld_pc, bus3.inc_pc, bus3.clr_pc, bus3.pass_add, bus3.halted, bus3.illegal_op};
   assign out0 = {bus0.rd_mem, bus0.wr_mem, bus0.ir_on_adr, bus0.pc_on_adr, bus0.ld_ir, bus0.ld_ac,
                  bus0.ld_pc, bus0.inc_pc, bus0.clr_pc, bus0.pass_add, bus0.halted, bus0.illegal_op};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic sel, input logic rst, input logic [2:0] op, input logic az,
                      input logic mr, input logic [2:0] st, input logic [11:0] out, input string nm);
      vec_t v;
      v.sel = sel; v.rst = rst; v.op = op; v.az = az; v.mr = mr;
      v.st = st; v.out = out; v.name = nm;
      vecs.push_back(v);
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected cycles of one instruction from FETCH through its last EXECUTE cycle.
   task automatic add_instr(input logic sel, input int waits, input logic [2:0] op, input logic az,
                            input int fstall, input int estall);
      for (int i = 0; i < fstall; i++) add(sel, 1'b0, op, az, 1'b0, ST_FETCH, O_RD | O_PCA, "fetch_stall");
      add(sel, 1'b0, op, az, 1'b1, ST_FETCH, O_RD | O_PCA | O_LDIR | O_INC, "fetch_ready");
      for (int i = 0; i < waits; i++) add(sel, 1'b0, op, az, rbit(), ST_WAIT, 12'h000, "wait");
      case (op)
         3'd0: add(sel, 1'b0, op, az, rbit(), ST_EXEC, O_PASS | O_LDAC, "exec_add");
         3'd1: begin
            for (int i = 0; i < estall; i++) add(sel, 1'b0, op, az, 1'b0, ST_EXEC, O_IRA | O_RD, "load_stall");
            add(sel, 1'b0, op, az, 1'b1, ST_EXEC, O_IRA | O_RD | O_LDAC, "load_ready");
         end
         3'd2: begin
            for (int i = 0; i < estall; i++) add(sel, 1'b0, op, az, 1'b0, ST_EXEC, O_IRA | O_WR, "stor_stall");
            add(sel, 1'b0, op, az, 1'b1, ST_EXEC, O_IRA | O_WR, "stor_ready");
         end
         3'd3: add(sel, 1'b0, op, az, rbit(), ST_EXEC, O_LDPC, "exec_jmp");
         3'd4: add(sel, 1'b0, op, az, rbit(), ST_EXEC, az ? O_LDPC : 12'h000, "exec_jz");
         3'd5: add(sel, 1'b0, op, az, rbit(), ST_EXEC, 12'h000, "exec_nop");
         3'd6: add(sel, 1'b0, op, az, rbit(), ST_EXEC, 12'h000, "exec_halt");
         default: add(sel, 1'b0, op, az, rbit(), ST_EXEC, 12'h000, "exec_op7");
      endcase
   endtask

   task automatic build_vectors();
      // reset hold and release on the 3-wait instance
      add(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, ST_RESET, O_CLR, "reset_hold");
      add(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, ST_RESET, O_CLR, "reset_hold");
      add(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, ST_RESET, O_CLR, "reset_release");
      add_instr(1'b0, 3, 3'd0, 1'b0, 0, 0);
      add_instr(1'b0, 3, 3'd1, 1'b0, 4, 2);
      add_instr(1'b0, 3, 3'd4, 1'b1, 0, 0);
      add_instr(1'b0, 3, 3'd4, 1'b0, 1, 0);
      add_instr(1'b0, 3, 3'd3, 1'b0, 0, 0);
      add_instr(1'b0, 3, 3'd3, 1'b1, 0, 0);
      add_instr(1'b0, 3, 3'd5, 1'b1, 0, 0);
      add_instr(1'b0, 3, 3'd2, 1'b0, 2, 3);
      for (int i = 0; i < 8; i++)
         add_instr(1'b0, 3, 3'($urandom_range(0, 5)), rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
      // reset during a FETCH stall
      add(1'b0, 1'b0, 3'd1, 1'b0, 1'b0, ST_FETCH, O_RD | O_PCA, "fetch_stall");
      add(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, ST_FETCH, O_RD | O_PCA, "reset_in_fetch");
      add(1'b0, 1'b0, 3'd6, 1'b0, 1'b1, ST_RESET, O_CLR, "after_fetch_reset");
      // HALT holds for 20 cycles, then reset escapes it
      add_instr(1'b0, 3, 3'd6, 1'b0, 0, 0);
      for (int i = 0; i < 20; i++)
         add(1'b0, 1'b0, 3'($urandom_range(0, 7)), rbit(), rbit(), ST_HALT, O_HLT, "halt_hold");
      add(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, ST_HALT, O_HLT, "halt_reset");
      add(1'b0, 1'b0, 3'd7, 1'b0, 1'b1, ST_RESET, O_CLR, "halt_exit");
      // opcode 111
      add_instr(1'b0, 3, 3'd7, 1'b1, 0, 0);
`ifdef ILLEGAL_OP_TRAP_EN
      for (int i = 0; i < 3; i++)
         add(1'b0, 1'b0, 3'($urandom_range(0, 7)), rbit(), rbit(), ST_HALT, O_HLT | O_ILL, "trap_halt");
      add(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, ST_HALT, O_HLT | O_ILL, "trap_reset");
      add(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, ST_RESET, O_CLR, "trap_clear");
`endif
      add_instr(1'b0, 3, 3'd0, 1'b0, 0, 0);
      // zero-wait instance: FETCH goes straight to EXECUTE
      add(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, ST_RESET, O_CLR, "reset0_hold");
      add(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, ST_RESET, O_CLR, "reset0_release");
      add_instr(1'b1, 0, 3'd0, 1'b0, 0, 0);
      add_instr(1'b1, 0, 3'd1, 1'b0, 2, 1);
      add_instr(1'b1, 0, 3'd4, 1'b1, 0, 0);
      add_instr(1'b1, 0, 3'd2, 1'b0, 0, 2);
      for (int i = 0; i < 4; i++)
         add_instr(1'b1, 0, 3'($urandom_range(0, 5)), rbit(), $urandom_range(0, 2), $urandom_range(0, 2));
      add_instr(1'b1, 0, 3'd7, 1'b0, 0, 0);
`ifdef ILLEGAL_OP_TRAP_EN
      add(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, ST_HALT, O_HLT | O_ILL, "trap0_halt");
      add(1'b1, 1'b0, 3'd5, 1'b1, 1'b0, ST_HALT, O_HLT | O_ILL, "trap0_halt");
`else
      add_instr(1'b1, 0, 3'd5, 1'b0, 0, 0);
`endif
   endtask

   // driver + scoreboard
   initial begin
      logic [14:0] act, exp_v;
      vec_t v;
      vectors_applied = 0;
      miscompares     = 0;
      rst3 = 1'b1;
      rst0 = 1'b1;
      bus3.op_code = '0; bus3.ac_zero = 1'b0; bus3.mem_ready = 1'b0;
      bus0.op_code = '0; bus0.ac_zero = 1'b0; bus0.mem_ready = 1'b0;
      build_vectors();
      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         if (v.sel == 1'b0) begin
            rst3 = v.rst; rst0 = 1'b1;
            bus3.op_code = v.op; bus3.ac_zero = v.az; bus3.mem_ready = v.mr;
         end else begin
            rst0 = v.rst; rst3 = 1'b1;
            bus0.op_code = v.op; bus0.ac_zero = v.az; bus0.mem_ready = v.mr;
         end
         exp_q.push_back({v.st, v.out});
         @(negedge clk);
         act   = v.sel ? {st0, out0} : {st3, out3};
         exp_v = exp_q.pop_front();
         vectors_applied++;
         if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s vec %0d dut%0d: got state=%0d out=%b, expected state=%0d out=%b",
                     v.name, i, v.sel ? 0 : 3, act[14:12], act[11:0], exp_v[14:12], exp_v[11:0]);
         end
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
